// File: rtl/axi_read_master.sv
// AXI4 read initiator: splits a (byte address, beat count) command into INCR
// bursts (max length and 4 KB page limited) and streams R data out unbuffered.
module axi_read_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int ARID          = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SZ = $clog2(STRB_WIDTH);
  localparam int BW = (LEN_WIDTH > 13) ? LEN_WIDTH + 1 : 14;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [LEN_WIDTH-1:0]  rem);
    logic [BW-1:0] room;
    logic [BW-1:0] cnt;
    room = BW'((13'd4096 - {1'b0, addr[11:0]}) >> SZ);
    cnt  = BW'(rem);
    if (cnt > BW'(MAX_BURST_LEN)) cnt = BW'(MAX_BURST_LEN);
    if (cnt > room) cnt = room;
    return 9'(cnt);
  endfunction

  function automatic logic [7:0] burst_arlen(input logic [ADDR_WIDTH-1:0] addr,
                                             input logic [LEN_WIDTH-1:0]  rem);
    return 8'(burst_beats(addr, rem) - 9'd1);
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic [8:0]              beat_cnt_q, beat_cnt_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    rd_hs;
  logic [ADDR_WIDTH-1:0]   cmd_addr_aligned;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    unused_rid;

  assign cmd_addr_aligned = cmd_addr & ALIGN_MASK;
  assign next_addr        = cur_addr_q + STEP;
  assign unused_rid       = ^m_axi_rid;

  // R channel is a straight wire-through while a burst is in flight.
  assign m_axi_rready = (state_q == DATA) && out_ready;
  assign out_valid    = (state_q == DATA) && m_axi_rvalid;
  assign out_data     = m_axi_rdata;
  assign out_last     = out_valid && (remaining_q == LEN_WIDTH'(1));
  assign rd_hs        = out_valid && out_ready;

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

  assign m_axi_arid    = ID_WIDTH'(ARID);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          if (cmd_beats == '0) begin
            done_d = 1'b1;
          end else begin
            cur_addr_d  = cmd_addr_aligned;
            remaining_d = cmd_beats;
            arvalid_d   = 1'b1;
            araddr_d    = cmd_addr_aligned;
            arlen_d     = burst_arlen(cmd_addr_aligned, cmd_beats);
            state_d     = ADDR;
          end
        end
      end

      ADDR: begin
        if (m_axi_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = {1'b0, arlen_q} + 9'd1;
          state_d    = DATA;
        end
      end

      DATA: begin
        if (rd_hs) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          beat_cnt_d  = beat_cnt_q - 9'd1;
          cur_addr_d  = next_addr;
          // Burst length is tracked locally; rlast is only cross-checked.
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt_q == 9'd1))) begin
            err_d = 1'b1;
          end
          if (beat_cnt_q == 9'd1) begin
            if (remaining_q == LEN_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              arvalid_d = 1'b1;
              araddr_d  = next_addr;
              arlen_d   = burst_arlen(next_addr, remaining_q - LEN_WIDTH'(1));
              state_d   = ADDR;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: behavioural AXI read slave (data = addr/4), a
// command-level expectation model, and a per-cycle compare process.
module tb_axi_read_master;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  m_axi_arid;
  logic [15:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  axi_read_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .ARID(0),
    .MAX_BURST_LEN(16), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int n_checks = 0;
  int n_pass   = 0;

  ar_t         exp_ar[$];
  beat_t       exp_beat[$];
  ar_t         ar_log[$];
  logic [31:0] beat_log[$];
  int          last_cnt, last_idx, done_cnt, stall_cnt, arvalid_cycles;

  int          ar_delay;
  logic [15:0] err_addr;
  bit          toggle_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected AR bursts and beats for one command, from the splitting rules.
  task automatic gen_expect(input logic [15:0] addr, input int beats);
    logic [15:0] a;
    int          rem, n, room;
    ar_t         ea;
    beat_t       eb;
    a   = addr & 16'hFFFC;
    rem = beats;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      n = rem;
      if (n > 16) n = 16;
      if (n > room) n = room;
      ea.addr = a;
      ea.len  = 8'(n - 1);
      exp_ar.push_back(ea);
      for (int i = 0; i < n; i++) begin
        eb.data = 32'(a >> 2);
        eb.last = ((rem - i) == 1);
        exp_beat.push_back(eb);
        a = a + 16'd4;
      end
      rem -= n;
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Downstream ready: steady high, or the 1,0,0 repeating pattern.
  initial begin
    int rcyc;
    rcyc = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = toggle_ready ? ((rcyc % 3) == 0) : 1'b1;
      rcyc++;
    end
  end

  // AXI read slave: one burst at a time, data = byte address / 4.
  initial begin
    bit          hs_ar, hs_r, s_active;
    logic [15:0] s_addr, cap_addr;
    int          s_left, s_wait;
    logic [7:0]  cap_len;
    hs_ar = 0; hs_r = 0; s_active = 0; s_addr = '0; s_left = 0; s_wait = 0;
    cap_addr = '0; cap_len = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 0; m_axi_rid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_ar = 0; hs_r = 0; s_active = 0; s_wait = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = '0;
      end else begin
        if (hs_ar) begin
          s_active = 1; s_addr = cap_addr; s_left = int'(cap_len) + 1; s_wait = 0;
        end
        if (hs_r) begin
          s_addr = s_addr + 16'd4;
          s_left--;
          if (s_left == 0) s_active = 0;
        end
        m_axi_arready = 1'b0;
        if (m_axi_arvalid && !s_active) begin
          if (s_wait >= ar_delay) m_axi_arready = 1'b1;
          else s_wait++;
        end
        m_axi_rvalid = s_active;
        m_axi_rdata  = 32'(s_addr >> 2);
        m_axi_rlast  = s_active && (s_left == 1);
        m_axi_rresp  = (s_active && (s_addr == err_addr)) ? 2'b10 : 2'b00;
        #1;
        hs_ar    = m_axi_arvalid && m_axi_arready;
        cap_addr = m_axi_araddr;
        cap_len  = m_axi_arlen;
        hs_r     = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  // Per-cycle comparison against the command-level model.
  initial begin
    bit          done_m, busy_m, err_m, prev_stall;
    logic [15:0] prev_addr;
    logic [7:0]  prev_len;
    ar_t         ea, la;
    beat_t       eb;
    done_m = 0; busy_m = 0; err_m = 0; prev_stall = 0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_ar.delete(); exp_beat.delete();
        done_m = 0; busy_m = 0; err_m = 0; prev_stall = 0;
      end else begin
        chk("done", done, done_m);
        chk("busy", busy, busy_m);
        chk("cmd_ready", cmd_ready, !busy_m);
        chk("err", err, err_m);
        chk("out_valid", out_valid, m_axi_rvalid);
        if (done) done_cnt++;
        if (m_axi_arvalid) arvalid_cycles++;
        if (prev_stall) begin
          chk("arvalid_hold", m_axi_arvalid, 1);
          chk("araddr_hold", m_axi_araddr, prev_addr);
          chk("arlen_hold", m_axi_arlen, prev_len);
        end
        done_m = 0;
        if (cmd_valid && cmd_ready) begin
          gen_expect(cmd_addr, int'(cmd_beats));
          err_m = 0;
          if (cmd_beats == 0) done_m = 1;
          else busy_m = 1;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            ea = exp_ar.pop_front();
            chk("araddr", m_axi_araddr, ea.addr);
            chk("arlen", m_axi_arlen, ea.len);
          end
          chk("arsize", m_axi_arsize, 2);
          chk("arburst", m_axi_arburst, 1);
          chk("arid", m_axi_arid, 0);
          chk("arcache", m_axi_arcache, 3);
          chk("arlock_prot", {m_axi_arlock, m_axi_arprot}, 0);
          la.addr = m_axi_araddr;
          la.len  = m_axi_arlen;
          ar_log.push_back(la);
        end
        if (m_axi_rvalid) chk("rready_mirror", m_axi_rready, out_ready);
        if (out_valid) chk("out_data_pass", out_data, m_axi_rdata);
        if (out_valid && !out_ready && exp_beat.size() > 0)
          chk("out_last_wait", out_last, exp_beat[0].last);
        if (out_valid && out_ready) begin
          if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
          else begin
            eb = exp_beat.pop_front();
            chk("out_data", out_data, eb.data);
            chk("out_last", out_last, eb.last);
            if (eb.last) begin
              done_m = 1;
              busy_m = 0;
            end
          end
          if (out_last) begin
            last_cnt++;
            last_idx = beat_log.size();
          end
          beat_log.push_back(out_data);
          if (m_axi_rresp != 2'b00) err_m = 1;
        end
        prev_stall = m_axi_arvalid && !m_axi_arready;
        prev_addr  = m_axi_araddr;
        prev_len   = m_axi_arlen;
        if (prev_stall) stall_cnt++;
      end
    end
  end

  task automatic clear_logs();
    ar_log.delete();
    beat_log.delete();
    last_cnt = 0; last_idx = -1; done_cnt = 0; stall_cnt = 0;
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] n, input bit chk_err,
                         output int lat);
    cmd_addr  = a;
    cmd_beats = n;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (chk_err) chk("err_cleared", err, 0);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) chk("done_timeout", done, 1);
    @(negedge clk);
  endtask

  initial begin
    int lat, arv_before;
    bit got;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    ar_delay = 0; err_addr = 16'hFFFF; toggle_ready = 1'b0;
    arvalid_cycles = 0;
    clear_logs();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_out", {out_valid, out_last, busy, done, err}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // single beat
    clear_logs();
    run_cmd(16'h0000, 16'd1, 1'b1, lat);
    chk("t1_ar_count", ar_log.size(), 1);
    if (ar_log.size() == 1) chk("t1_ar", {ar_log[0].addr, ar_log[0].len}, {16'h0000, 8'd0});
    chk("t1_beats", beat_log.size(), 1);
    if (beat_log.size() == 1) chk("t1_data", beat_log[0], 32'h0);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_done_lat", lat, 2);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", err, 0);

    // split at burst cap
    clear_logs();
    run_cmd(16'h0004, 16'd20, 1'b0, lat);
    chk("t2_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t2_ar0", {ar_log[0].addr, ar_log[0].len}, {16'h0004, 8'd15});
      chk("t2_ar1", {ar_log[1].addr, ar_log[1].len}, {16'h0044, 8'd3});
    end
    chk("t2_beats", beat_log.size(), 20);
    if (beat_log.size() == 20) begin
      chk("t2_first", beat_log[0], 32'd1);
      chk("t2_17th", beat_log[16], 32'd17);
      chk("t2_final", beat_log[19], 32'd20);
    end
    chk("t2_last_cnt", last_cnt, 1);
    chk("t2_last_idx", last_idx, 19);
    chk("t2_done_cnt", done_cnt, 1);

    // split at 4 KB boundary
    clear_logs();
    run_cmd(16'h0FF8, 16'd4, 1'b0, lat);
    chk("t3_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t3_ar0", {ar_log[0].addr, ar_log[0].len}, {16'h0FF8, 8'd1});
      chk("t3_ar1", {ar_log[1].addr, ar_log[1].len}, {16'h1000, 8'd1});
    end
    chk("t3_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk("t3_d0", beat_log[0], 32'h3FE);
      chk("t3_d1", beat_log[1], 32'h3FF);
      chk("t3_d2", beat_log[2], 32'h400);
      chk("t3_d3", beat_log[3], 32'h401);
    end

    // downstream backpressure and slow arready
    clear_logs();
    ar_delay = 3;
    toggle_ready = 1'b1;
    run_cmd(16'h0200, 16'd8, 1'b0, lat);
    toggle_ready = 1'b0;
    ar_delay = 0;
    chk("t4_beats", beat_log.size(), 8);
    if (beat_log.size() == 8) begin
      chk("t4_d0", beat_log[0], 32'h80);
      chk("t4_d4", beat_log[4], 32'h84);
      chk("t4_d7", beat_log[7], 32'h87);
    end
    chk("t4_ar_stall", stall_cnt, 3);
    chk("t4_done_cnt", done_cnt, 1);

    // zero-beat command
    clear_logs();
    arv_before = arvalid_cycles;
    run_cmd(16'h0100, 16'd0, 1'b0, lat);
    chk("t5_done_lat", lat, 0);
    chk("t5_done_off", done, 0);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_no_arvalid", arvalid_cycles - arv_before, 0);
    chk("t5_no_ar", ar_log.size(), 0);

    // error response on beat 2 of 4
    clear_logs();
    err_addr = 16'h0104;
    run_cmd(16'h0100, 16'd4, 1'b0, lat);
    err_addr = 16'hFFFF;
    chk("t5_err_beats", beat_log.size(), 4);
    if (beat_log.size() == 4) chk("t5_err_d1", beat_log[1], 32'h41);
    chk("t5_err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", err, 1);
    clear_logs();
    run_cmd(16'h0000, 16'd1, 1'b1, lat);
    chk("t5_err_after", err, 0);

    // reset during beat 3 of a 16-beat burst
    clear_logs();
    cmd_addr = 16'h0200; cmd_beats = 16'd16; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #3;
      if (beat_log.size() >= 2) begin
        got = 1;
        break;
      end
    end
    chk("t6_reached_beat2", got, 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_arvalid", m_axi_arvalid, 0);
    chk("t6_rready", m_axi_rready, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    run_cmd(16'h0040, 16'd2, 1'b1, lat);
    chk("t6_ar", ar_log.size(), 1);
    if (ar_log.size() == 1) chk("t6_ar0", {ar_log[0].addr, ar_log[0].len}, {16'h0040, 8'd1});
    chk("t6_beats", beat_log.size(), 2);
    if (beat_log.size() == 2) begin
      chk("t6_d0", beat_log[0], 32'h10);
      chk("t6_d1", beat_log[1], 32'h11);
    end
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_err", err, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
